// File: rtl/frs_message_queue_pkg.sv
// Shared types and constants for the FRS message queue: message record,
// status bit positions and the FRS reason codes carried by inbound messages.
package frs_pkg;

  typedef struct packed {
    logic [3:0]  reason;
    logic [15:0] func_id;
  } frs_msg_t;

  localparam int STS_RCVD_BIT = 0;
  localparam int STS_OVFL_BIT = 1;

  localparam logic [3:0] DRS_RCVD    = 4'b0001;
  localparam logic [3:0] D3HOT_D0    = 4'b0010;
  localparam logic [3:0] FLR_DONE    = 4'b0011;
  localparam logic [3:0] VF_EN_DONE  = 4'b1000;
  localparam logic [3:0] VF_DIS_DONE = 4'b1001;

  // Width needed to hold a count of 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/frs_message_queue_if.sv
// Bundle of message-ingress, register-access and interrupt signals between the
// FRS message queue and its neighbours (decoder, register file, MSI engine).
interface frs_message_queue_if #(
  parameter int QUEUE_DEPTH = 32,
  parameter int CNT_W       = $clog2(QUEUE_DEPTH + 1)
);
  logic             msg_valid;
  logic [15:0]      msg_func_id;
  logic [3:0]       msg_reason;
  logic             frs_interrupt_enable;
  logic             queue_pop;
  logic [31:0]      queue_rd_data;
  logic             status_wr_en;
  logic [15:0]      status_wr_data;
  logic [15:0]      status_rd_data;
  logic [11:0]      max_depth;
  logic [CNT_W-1:0] queue_count;
  logic             irq_req;
  logic             irq_ack;

  modport master (
    output msg_valid, msg_func_id, msg_reason, frs_interrupt_enable,
    output queue_pop, status_wr_en, status_wr_data, irq_ack,
    input  queue_rd_data, status_rd_data, max_depth, queue_count, irq_req
  );

  modport slave (
    input  msg_valid, msg_func_id, msg_reason, frs_interrupt_enable,
    input  queue_pop, status_wr_en, status_wr_data, irq_ack,
    output queue_rd_data, status_rd_data, max_depth, queue_count, irq_req
  );
endinterface

// File: rtl/frs_message_queue_fifo.sv
// Synchronous FIFO of FRS messages. A pop and a push in the same cycle are both
// honoured even when full, so the slot freed by the pop takes the new entry.
module frs_msg_fifo
  import frs_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  frs_msg_t         wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output frs_msg_t         head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  frs_msg_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;
  logic             do_push;

  // Explicit wrap so non-power-of-two depths never index past the last slot.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/frs_message_queue.sv
// Receive side of FRS queueing: buffers inbound FRS messages, exposes the head
// entry and RW1C status, and raises a held interrupt gated by the enable bit.
module frs_message_queue
  import frs_pkg::*;
#(
  parameter int QUEUE_DEPTH = 32
) (
  input logic                clk,
  input logic                rst_n,
  frs_message_queue_if.slave bus
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  frs_msg_t         msg_in;
  frs_msg_t         head;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             pop_ok;
  logic             push_ok;
  logic             ovfl_evt;
  logic             rcvd_clr;
  logic             ovfl_clr;
  logic             en_rise;
  logic             irq_set;
  logic             rcvd;
  logic             ovfl;
  logic             irq_pend;
  logic             en_p1;

  assign msg_in.reason  = bus.msg_reason;
  assign msg_in.func_id = bus.msg_func_id;

  frs_msg_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.msg_valid),
    .wdata (msg_in),
    .pop   (bus.queue_pop),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  // Acceptance mirrors the FIFO: a full queue still takes a push when popped.
  assign pop_ok   = bus.queue_pop && !empty;
  assign push_ok  = bus.msg_valid && (!full || pop_ok);
  assign ovfl_evt = bus.msg_valid && !push_ok;

  assign rcvd_clr = bus.status_wr_en && bus.status_wr_data[STS_RCVD_BIT];
  assign ovfl_clr = bus.status_wr_en && bus.status_wr_data[STS_OVFL_BIT];

  // Enabling while a message is already latched must still notify software.
  assign en_rise  = bus.frs_interrupt_enable && !en_p1;
  assign irq_set  = bus.frs_interrupt_enable && (push_ok || (en_rise && rcvd));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcvd     <= 1'b0;
      ovfl     <= 1'b0;
      irq_pend <= 1'b0;
      en_p1    <= 1'b0;
    end else begin
      rcvd  <= push_ok  || (rcvd && !rcvd_clr);
      ovfl  <= ovfl_evt || (ovfl && !ovfl_clr);
      en_p1 <= bus.frs_interrupt_enable;
      if (!bus.frs_interrupt_enable || bus.irq_ack) irq_pend <= 1'b0;
      else if (irq_set)                             irq_pend <= 1'b1;
    end
  end

  assign bus.queue_rd_data  = empty ? 32'h0 : {12'h0, head};
  assign bus.status_rd_data = {14'h0, ovfl, rcvd};
  assign bus.max_depth      = 12'(QUEUE_DEPTH - 1);
  assign bus.queue_count    = count;
  assign bus.irq_req        = irq_pend;

endmodule
